// File: rtl/pipe_mem_ctrl.sv
// Pipeline sequencing controller: arbitrates the single shared RAM port between
// instruction fetch and data memory, and merges all stall sources into the
// 6-bit stall vector that drives the PC and the pipeline registers.
module pipe_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  // instruction fetch side
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  // data memory side
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  // shared RAM port
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  // stall sources and result
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  output logic [5:0]  stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StData
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              timeout_hit;
  logic              sreq_mem;
  logic              sreq_if;

  // Last waiting cycle of a transaction with no ready: abort instead of counting on.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1)) && !ram_ready;

  // State, latched request and sticky error registers; synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Arbitration (MEM over IF), completion, and timeout handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    if_done  = 1'b0;
    mem_done = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (mem_req) begin
          state_d = StData;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_we;
        end else if (if_req) begin
          state_d = StFetch;
          addr_d  = if_addr;
          we_d    = 1'b0;
        end
      end
      StFetch, StData: begin
        if (ram_ready) begin
          if_done  = (state_q == StFetch);
          mem_done = (state_q == StData);
          state_d  = StIdle;
          cnt_d    = '0;
        end else if (timeout_hit) begin
          // Requester keeps waiting and is re-arbitrated from idle.
          err_d   = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stall merge: highest-priority source decides how far back the pipeline freezes.
  always_comb begin
    sreq_mem = mem_req && !mem_done;
    sreq_if  = if_req && !if_done;
    stall    = 6'b000000;
    if (sreq_mem) begin
      stall = 6'b011111;
    end else if (stallreq_ex) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else if (sreq_if) begin
      stall = 6'b000011;
    end
  end

  assign ram_req   = (state_q != StIdle);
  assign ram_we    = (state_q == StData) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: directed scenarios plus randomized
// requesters, checked by a queue-based scoreboard and a stall-priority model.
module tb_pipe_mem_ctrl;

  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_done, mem_done, ram_req, ram_we, ram_ready;
  logic        stallreq_id, stallreq_ex, mem_err;
  logic [5:0]  stall;

  pipe_mem_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stall(stall), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        if_q[$];
  txn_t        mem_q[$];
  int          done_log[$];
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int   checks = 0;
  int   errors = 0;
  int   n_if = 0;
  int   n_mem = 0;
  int   ram_lat = 0;
  bit   rand_lat = 1'b0;
  logic resp_ready = 1'b0;
  logic force_ready = 1'b0;
  logic last_if_done = 1'b0;
  logic last_mem_done = 1'b0;
  logic last_stall0 = 1'b0;

  assign ram_ready = resp_ready | force_ready;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Spec priority table for the stall vector.
  function automatic logic [5:0] ref_stall(input logic m, input logic ex, input logic id,
                                           input logic f);
    if (m) return 6'b011111;
    if (ex) return 6'b001111;
    if (id) return 6'b000111;
    if (f) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_if(input logic [31:0] a);
    txn_t t;
    t = '{addr: a, we: 1'b0, wdata: 32'h0, rdata: init_word(a)};
    if_req  = 1'b1;
    if_addr = a;
    if_q.push_back(t);
  endtask

  task automatic issue_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t = '{addr: a, we: we, wdata: d, rdata: (we ? 32'h0 : ref_read(a))};
    if (we) ref_mem[a] = d;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    mem_q.push_back(t);
  endtask

  task automatic wait_done(input bit want_mem, input int budget, input string name);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge CLK);
      got = want_mem ? mem_done : if_done;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles (got 0 expected 1)", name, budget);
    end
  endtask

  // RAM model: ready after ram_lat wait cycles; read data from the backing array.
  initial begin
    int wcnt;
    wcnt = 0;
    ram_rdata = 32'h0;
    forever begin
      tick();
      ram_rdata = ram_read(ram_addr);
      if (!ram_req) begin
        wcnt = 0;
        resp_ready = 1'b0;
        if (rand_lat) ram_lat = int'($urandom_range(0, 3));
      end else if (resp_ready) begin
        resp_ready = 1'b0;
      end else if (wcnt == ram_lat) begin
        resp_ready = 1'b1;
      end else begin
        wcnt++;
      end
    end
  end

  // RAM write port.
  initial forever begin
    @(negedge CLK);
    if (!RST && ram_req && ram_ready && ram_we) ram_mem[ram_addr] = ram_wdata;
  end

  // Monitor: done pulses, stall priority and scoreboard pops.
  initial forever begin
    logic exp_if, exp_mem;
    txn_t t;
    @(negedge CLK);
    last_if_done  = if_done;
    last_mem_done = mem_done;
    last_stall0   = stall[0];
    if (!RST) begin
      exp_if  = ram_req && ram_ready && (ram_addr < 32'h1000);
      exp_mem = ram_req && ram_ready && (ram_addr >= 32'h1000);
      chk("if_done", {31'h0, if_done}, {31'h0, exp_if});
      chk("mem_done", {31'h0, mem_done}, {31'h0, exp_mem});
      chk("stall", {26'h0, stall},
          {26'h0, ref_stall(mem_req && !exp_mem, stallreq_ex, stallreq_id, if_req && !exp_if)});
      if (if_done) begin
        n_if++;
        done_log.push_back(1);
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_unexpected: got if_done=1 expected no pending fetch");
        end else begin
          t = if_q.pop_front();
          chk("if_addr", ram_addr, t.addr);
          chk("if_we", {31'h0, ram_we}, 32'h0);
          chk("if_rdata", if_rdata, t.rdata);
        end
      end
      if (mem_done) begin
        n_mem++;
        done_log.push_back(2);
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got mem_done=1 expected no pending access");
        end else begin
          t = mem_q.pop_front();
          chk("mem_addr", ram_addr, t.addr);
          chk("mem_we", {31'h0, ram_we}, {31'h0, t.we});
          if (t.we) chk("mem_wdata", ram_wdata, t.wdata);
          else chk("mem_rdata", mem_rdata, t.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    RST = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    stallreq_id = 1'b0; stallreq_ex = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ram_req", {31'h0, ram_req}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_stall", {26'h0, stall}, 32'h0);
    chk("rst_mem_err", {31'h0, mem_err}, 32'h0);

    // Fetch with one wait cycle.
    tick();
    ram_lat = 1;
    nb = n_if;
    issue_if(32'h100);
    @(negedge CLK);
    chk("t1_idle_ram_req", {31'h0, ram_req}, 32'h0);
    chk("t1_idle_stall", {26'h0, stall}, 32'h3);
    tick();
    @(negedge CLK);
    chk("t1_ram_addr", ram_addr, 32'h100);
    chk("t1_ram_we", {31'h0, ram_we}, 32'h0);
    chk("t1_wait_stall", {26'h0, stall}, 32'h3);
    wait_done(1'b0, 4, "t1_done");
    chk("t1_done_stall", {26'h0, stall}, 32'h0);
    tick();
    if_req = 1'b0;
    @(negedge CLK);
    chk("t1_done_count", n_if - nb, 1);

    // Simultaneous requests: MEM wins, then FETCH.
    tick();
    done_log.delete();
    issue_if(32'h180);
    issue_mem(1'b1, 32'h2000, 32'hDEADBEEF);
    tick();
    @(negedge CLK);
    chk("t2_ram_we", {31'h0, ram_we}, 32'h1);
    chk("t2_ram_addr", ram_addr, 32'h2000);
    chk("t2_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("t2_stall", {26'h0, stall}, 32'h1F);
    wait_done(1'b1, 6, "t2_mem_done");
    tick();
    mem_req = 1'b0;
    @(negedge CLK);
    chk("t2_gap_ram_req", {31'h0, ram_req}, 32'h0);
    tick();
    @(negedge CLK);
    chk("t2_fetch_addr", ram_addr, 32'h180);
    chk("t2_fetch_we", {31'h0, ram_we}, 32'h0);
    wait_done(1'b0, 6, "t2_if_done");
    tick();
    if_req = 1'b0;
    chk("t2_order_n", done_log.size(), 2);
    if (done_log.size() == 2) begin
      chk("t2_order0", done_log[0], 2);
      chk("t2_order1", done_log[1], 1);
    end

    // MEM arrives during a 3-cycle fetch: fetch finishes, data, then refetch.
    tick();
    done_log.delete();
    ram_lat = 2;
    issue_if(32'h140);
    tick();
    tick();
    issue_mem(1'b0, 32'h2000, 32'h0);
    wait_done(1'b0, 8, "t3_if_done");
    chk("t3_if_done_stall", {26'h0, stall}, 32'h1F);
    tick();
    issue_if(32'h140);
    wait_done(1'b1, 8, "t3_mem_done");
    tick();
    mem_req = 1'b0;
    wait_done(1'b0, 8, "t3_refetch_done");
    chk("t3_refetch_stall", {26'h0, stall}, 32'h0);
    tick();
    if_req = 1'b0;
    chk("t3_order_n", done_log.size(), 3);
    if (done_log.size() == 3) begin
      chk("t3_order0", done_log[0], 1);
      chk("t3_order1", done_log[1], 2);
      chk("t3_order2", done_log[2], 1);
    end

    // Stall priority without memory traffic.
    tick();
    stallreq_ex = 1'b1;
    stallreq_id = 1'b1;
    @(negedge CLK);
    chk("t4_ex_id", {26'h0, stall}, 32'hF);
    tick();
    stallreq_ex = 1'b0;
    @(negedge CLK);
    chk("t4_id", {26'h0, stall}, 32'h7);
    tick();
    stallreq_id = 1'b0;
    @(negedge CLK);
    chk("t4_none", {26'h0, stall}, 32'h0);

    // Timeout on a read that never completes, then re-grant.
    tick();
    ram_lat = -1;
    nb = n_mem;
    issue_mem(1'b0, 32'h2004, 32'h0);
    @(negedge CLK);
    chk("t5_idle_ram_req", {31'h0, ram_req}, 32'h0);
    for (int i = 0; i < int'(TO); i++) begin
      tick();
      @(negedge CLK);
      chk("t5_wait_ram_req", {31'h0, ram_req}, 32'h1);
      chk("t5_wait_err", {31'h0, mem_err}, 32'h0);
    end
    tick();
    ram_lat = 0;
    @(negedge CLK);
    chk("t5_abort_ram_req", {31'h0, ram_req}, 32'h0);
    chk("t5_abort_err", {31'h0, mem_err}, 32'h1);
    chk("t5_no_done", n_mem - nb, 0);
    tick();
    @(negedge CLK);
    chk("t5_regrant", {31'h0, ram_req}, 32'h1);
    chk("t5_regrant_done", {31'h0, mem_done}, 32'h1);
    tick();
    mem_req = 1'b0;
    @(negedge CLK);
    chk("t5_err_sticky", {31'h0, mem_err}, 32'h1);
    chk("t5_done_count", n_mem - nb, 1);

    // Reset in the middle of a data access.
    tick();
    ram_lat = -1;
    issue_mem(1'b0, 32'h2008, 32'h0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mem_req = 1'b0;
    mem_q.delete();
    @(negedge CLK);
    chk("t6_ram_req", {31'h0, ram_req}, 32'h0);
    chk("t6_stall", {26'h0, stall}, 32'h0);
    chk("t6_mem_err", {31'h0, mem_err}, 32'h0);
    chk("t6_ram_addr", ram_addr, 32'h0);
    tick();
    force_ready = 1'b1;
    @(negedge CLK);
    chk("t6_idle_ready_if", {31'h0, if_done}, 32'h0);
    chk("t6_idle_ready_mem", {31'h0, mem_done}, 32'h0);
    tick();
    force_ready = 1'b0;

    // Randomized requesters; fetch repeats its address when the PC was held.
    rand_lat = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      tick();
      stallreq_ex = ($urandom_range(0, 7) == 0);
      stallreq_id = ($urandom_range(0, 5) == 0);
      if (if_req) begin
        if (last_if_done) begin
          if (last_stall0) issue_if(if_addr);
          else if ($urandom_range(0, 3) == 0) if_req = 1'b0;
          else issue_if(32'($urandom_range(0, 1023)) << 2);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        issue_if(32'($urandom_range(0, 1023)) << 2);
      end
      if (mem_req) begin
        if (last_mem_done) begin
          if ($urandom_range(0, 2) == 0) mem_req = 1'b0;
          else issue_mem(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 15)) << 2),
                         $urandom);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        issue_mem(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 15)) << 2),
                  $urandom);
      end
    end

    // Drain outstanding requests.
    stallreq_ex = 1'b0;
    stallreq_id = 1'b0;
    for (int c = 0; c < 100 && (if_req || mem_req); c++) begin
      tick();
      if (if_req && last_if_done) if_req = 1'b0;
      if (mem_req && last_mem_done) mem_req = 1'b0;
    end
    tick();
    @(negedge CLK);
    chk("end_if_pending", if_q.size(), 0);
    chk("end_mem_pending", mem_q.size(), 0);
    chk("end_mem_err", {31'h0, mem_err}, 32'h0);
    chk("end_ram_req", {31'h0, ram_req}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_mem_ctrl.md
Name: pipe_mem_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It arbitrates the single shared RAM port between instruction fetch (IF) and data memory (MEM), and merges memory-busy, EX multi-cycle and ID load-use stall requests into the 6-bit stall vector that drives the PC and every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB). A pipeline register inserts a bubble when stall[k] is high and stall[k+1] is low, and holds when both are high.

Parameters:
TIMEOUT, 255, maximum cycles a RAM transaction waits for ram_ready before it is aborted; must be at least 1.
CNT_W, 8, width of the wait counter; 2^CNT_W must be greater than TIMEOUT.

Ports:
CLK  input  1  clock
RST  input  1  synchronous reset, active-high
if_req  input  1  fetch request; held until if_done
if_addr  input  32  fetch address
if_rdata  output  32  fetched word; combinational pass-through of ram_rdata
if_done  output  1  fetch complete; 1-cycle pulse
mem_req  input  1  data access request; held until mem_done
mem_we  input  1  1 = write, 0 = read
mem_addr  input  32  data address
mem_wdata  input  32  write data
mem_rdata  output  32  read data; pass-through of ram_rdata
mem_done  output  1  data access complete; 1-cycle pulse
ram_req  output  1  RAM transaction active
ram_we  output  1  RAM write enable
ram_addr  output  32  RAM address (registered)
ram_wdata  output  32  RAM write data (registered)
ram_ready  input  1  RAM completes the current transaction this cycle
stallreq_id  input  1  load-use hazard from decode
stallreq_ex  input  1  multi-cycle ALU busy
stall  output  6  [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB
mem_err  output  1  sticky timeout flag; cleared only by RST

Behaviour:
- FSM states: IDLE, FETCH, DATA. Reset (synchronous, including mid-transaction): state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, wait counter=0, mem_err=0. ram_req, if_done, mem_done and stall are therefore all 0 in the cycle after RST.
- ram_req = (state != IDLE). ram_we is 1 only in DATA with a latched write.
- IDLE transitions:
  - mem_req=1: go to DATA; latch mem_addr, mem_wdata and mem_we. MEM has priority over IF when both are high.
  - else if_req=1: go to FETCH; latch if_addr; ram_we=0.
  - else stay in IDLE.
- FETCH/DATA with ram_ready=1:
  - Assert if_done (FETCH) or mem_done (DATA) in the same cycle, combinationally. The rdata outputs are valid that cycle.
  - Return to IDLE and clear the counter.
  - Minimum latency is 2 cycles, request to done. Back-to-back transactions need an intervening IDLE cycle.
- A mem_req arriving during FETCH waits until the fetch completes; there is no abort. A new request cannot be granted while a transaction is in progress.
- Timeout: the counter increments each cycle in FETCH or DATA without ram_ready.
  - When counter = TIMEOUT-1 and ram_ready=0: set mem_err, go to IDLE, and assert no done.
  - The requester is still waiting, so it is re-arbitrated from IDLE.
- Internal stall requests:
  - sreq_mem = mem_req & ~mem_done
  - sreq_if = if_req & ~if_done
- Stall priority (first match wins):
  - sreq_mem: 6'b011111
  - stallreq_ex: 6'b001111
  - stallreq_id: 6'b000111
  - sreq_if: 6'b000011
  - none: 6'b000000
- stall is combinational from the current state and inputs; there is no added latency.
- Fetch completing while a higher-priority stall holds the PC: the word is discarded, and IF re-requests the same address. This refetch is the required behaviour; there is no fetch buffer.
- Requesters must keep req, addr and wdata stable until done. The controller latches at grant and ignores later changes until done.
- ram_ready while in IDLE is ignored.

Test Plan:
- Reset, then if_req=1 with if_addr=0x100 and ram_ready after 1 wait cycle -> ram_addr=0x100 and ram_we=0; stall=000011 until if_done; if_done pulses exactly once; stall=000000 in the done cycle.
- if_req and mem_req both high in IDLE, mem_we=1, mem_addr=0x2000, mem_wdata=0xDEADBEEF -> DATA is granted first with ram_we=1 and the latched values; stall=011111; after mem_done, FETCH is granted next.
- mem_req rises 1 cycle into a 3-cycle fetch -> fetch completes (if_done=1 while stall=011111); DATA starts the next cycle; mem_done arrives and IF refetches the same address.
- stallreq_ex=1 with stallreq_id=1, no memory activity -> stall=001111; drop stallreq_ex -> stall=000111; drop stallreq_id -> 000000.
- TIMEOUT=4 with ram_ready held at 0 during a read -> after 4 cycles in DATA, mem_err=1 (sticky), state returns to IDLE, mem_done is never pulsed, and the request is re-granted.
- RST asserted mid-DATA -> next cycle ram_req=0, stall=000000, mem_err=0; a ram_ready after reset produces no done pulse.
